// File: rtl/mac_pkg.sv
// Shared definitions for the streaming MAC unit.
// Holds the packet mode codes, the packet-control FSM encoding and the
// elaboration-time width check used by the top.
package mac_pkg;

  typedef logic [1:0] mac_mode_t;

  localparam mac_mode_t MAC_DOT    = 2'd0;
  localparam mac_mode_t MAC_HORNER = 2'd1;
  localparam mac_mode_t MAC_LINEAR = 2'd2;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StAccum = 1'b1
  } mac_state_e;

  // The accumulator must hold a full product plus one carry bit.
  function automatic bit acc_w_ok(int unsigned data_w, int unsigned acc_w);
    return acc_w >= 2 * data_w + 1;
  endfunction

  // Reserved code 3 decodes exactly like LINEAR.
  function automatic bit is_linear(mac_mode_t mode);
    return (mode != MAC_DOT) && (mode != MAC_HORNER);
  endfunction

endpackage

// File: rtl/mac_sat_step.sv
// One combinational accumulator step for the streaming MAC unit.
// Forms the step result at full width, flags any bits above ACC_W-1 and
// optionally clamps to all-ones.
//   mode_i : packet mode (DOT / HORNER / LINEAR, 3 acts as LINEAR)
//   acc_i  : accumulator value entering the step (already cleared on packet start)
//   a_i, b_i, c_i : beat operands
//   res_o  : ACC_W-bit step result (clamped or wrapped)
//   ovf_o  : the full-width result did not fit in ACC_W bits
module mac_sat_step
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ACC_W    = 20,
  parameter bit          SATURATE = 1'b1
) (
  input  mac_mode_t          mode_i,
  input  logic [ACC_W-1:0]   acc_i,
  input  logic [DATA_W-1:0]  a_i,
  input  logic [DATA_W-1:0]  b_i,
  input  logic [DATA_W-1:0]  c_i,
  output logic [ACC_W-1:0]   res_o,
  output logic               ovf_o
);

  // Wide enough for acc*b + a, the largest of the three forms.
  localparam int unsigned FullW = ACC_W + DATA_W + 1;

  logic [FullW-1:0] acc_x, a_x, b_x, c_x, full;

  assign acc_x = FullW'(acc_i);
  assign a_x   = FullW'(a_i);
  assign b_x   = FullW'(b_i);
  assign c_x   = FullW'(c_i);

  always_comb begin
    full = '0;
    case (mode_i)
      MAC_DOT:    full = acc_x + a_x * b_x;
      MAC_HORNER: full = acc_x * b_x + a_x;
      default:    full = a_x * b_x + c_x;
    endcase
  end

  always_comb begin
    ovf_o = |full[FullW-1:ACC_W];
    res_o = (SATURATE && ovf_o) ? '1 : full[ACC_W-1:0];
  end

endmodule

// File: rtl/mac_stream_unit.sv
// Streaming multiply-accumulate unit with packetised mode selection.
// Two-stage pipeline: S1 registers the accepted beat, S2 runs one accumulator
// step and loads the output register on the packet's last beat.
//   clk, reset_n          : clock, asynchronous active-low reset
//   in_valid/in_ready     : operand beat handshake
//   in_a, in_b, in_c      : operands (HORNER: coefficient / x; c used in LINEAR only)
//   in_last               : final beat of packet (ignored in LINEAR)
//   in_mode               : sampled on the first beat of a packet
//   out_valid/out_ready   : result handshake
//   out_data, out_ovf     : result and sticky packet overflow flag
module mac_stream_unit
  import mac_pkg::*;
#(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ACC_W    = 20,
  parameter bit          SATURATE = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_c,
  input  logic              in_last,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf
);

  if (!acc_w_ok(DATA_W, ACC_W)) begin : gen_acc_w_check
    $error("mac_stream_unit: ACC_W must be at least 2*DATA_W+1");
  end

  // Packet control
  mac_state_e state_q, state_d;
  mac_mode_t  mode_q, mode_d;

  // S1 beat register
  logic              s1_valid_q, s1_valid_d;
  logic [DATA_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_c_q, s1_c_d;
  logic              s1_first_q, s1_first_d, s1_last_q, s1_last_d;
  mac_mode_t         s1_mode_q, s1_mode_d;

  // S2 accumulator and output register
  logic [ACC_W-1:0]  acc_q, acc_d, out_data_q, out_data_d;
  logic              ovf_q, ovf_d, out_valid_q, out_valid_d, out_ovf_q, out_ovf_d;

  logic              advance, accept, beat_first, beat_last;
  mac_mode_t         beat_mode;
  logic [ACC_W-1:0]  step_acc, step_res, acc_new;
  logic              step_ovf, ovf_pkt;

  // Whole pipeline stalls only while a result is waiting on the collector.
  assign advance  = !(out_valid_q && !out_ready);
  assign accept   = in_valid && advance;
  assign in_ready = advance;

  assign beat_first = (state_q == StIdle);
  assign beat_mode  = beat_first ? in_mode : mode_q;
  assign beat_last  = is_linear(beat_mode) || in_last;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    if (accept) begin
      mode_d  = beat_mode;
      state_d = beat_last ? StIdle : StAccum;
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_c_d     = s1_c_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    s1_mode_d  = s1_mode_q;
    if (advance) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_a_d     = in_a;
        s1_b_d     = in_b;
        s1_c_d     = in_c;
        s1_first_d = beat_first;
        s1_last_d  = beat_last;
        s1_mode_d  = beat_mode;
      end
    end
  end

  // A packet's first beat starts from a cleared accumulator and flag.
  assign step_acc = s1_first_q ? '0 : acc_q;

  mac_sat_step #(
    .DATA_W   (DATA_W),
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_step (
    .mode_i (s1_mode_q),
    .acc_i  (step_acc),
    .a_i    (s1_a_q),
    .b_i    (s1_b_q),
    .c_i    (s1_c_q),
    .res_o  (step_res),
    .ovf_o  (step_ovf)
  );

  // Once saturated, stay pinned for the rest of the packet even if a later
  // step (e.g. HORNER with x=0) would fit again.
  assign ovf_pkt = (s1_first_q ? 1'b0 : ovf_q) | step_ovf;
  assign acc_new = (SATURATE && ovf_pkt) ? '1 : step_res;

  always_comb begin
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    if (advance) begin
      out_valid_d = s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        acc_d = acc_new;
        ovf_d = ovf_pkt;
        if (s1_last_q) begin
          out_data_d = acc_new;
          out_ovf_d  = ovf_pkt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      mode_q      <= MAC_DOT;
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_c_q      <= '0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_mode_q   <= MAC_DOT;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_c_q      <= s1_c_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_mode_q   <= s1_mode_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: doc/mac_stream_unit.md
# mac_stream_unit

Parametrised, streaming successor to the fixed 8-bit MAC datapath. It takes operand beats over a valid/ready handshake and computes one of three per-packet functions: dot-product accumulate, Horner polynomial evaluation, or per-beat linear `a*b+c`. Results are emitted over a valid/ready output with optional saturation and an overflow flag. It sits between the operand sequencer and the result collector, and replaces hard-wired mux selects with a packetised mode field.

## Interface
- `DATA_W`, 8: operand width (unsigned)
- `ACC_W`, 20: accumulator/result width (unsigned), must be ≥ 2*DATA_W+1
- `SATURATE`, 1: 1 clamps to all-ones on overflow; 0 wraps modulo 2^ACC_W
- `clk`  in  1  single clock, rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  operand beat valid
- `in_ready`  out  1  unit can accept a beat
- `in_a`, `in_b`  in  DATA_W  multiplicand / multiplier (Horner: coefficient / x)
- `in_c`  in  DATA_W  addend, LINEAR mode only
- `in_last`  in  1  final beat of packet
- `in_mode`  in  2  0 DOT, 1 HORNER, 2 LINEAR, 3 reserved (treated as LINEAR)
- `out_valid`  out  1  result valid
- `out_ready`  in  1  collector accepts result
- `out_data`  out  ACC_W  result
- `out_ovf`  out  1  overflow occurred in this packet

## Operation
- Beat transfer: `in_valid && in_ready` at a rising edge. Result transfer: `out_valid && out_ready`.
- `in_mode` is sampled on the first beat of a packet and held internally until its last beat. Mid-packet changes are ignored. In LINEAR, every beat is both first and last, so `in_last` is ignored.
- Accumulator clears to 0 at the start of each packet.
  - DOT: acc ← acc + a*b.
  - HORNER: acc ← acc*b + a. Beats carry coefficients highest-order first, with x in `in_b`.
  - LINEAR: result ← a*b + c.
- Width rules:
  - Products are formed at full width: 2*DATA_W, or ACC_W+DATA_W for HORNER.
  - Overflow is any nonzero bit above ACC_W−1 in the full-width result of a step.
  - On overflow: the sticky packet `ovf` flag is set. With SATURATE=1, acc is forced to 2^ACC_W−1 and held there for the rest of the packet. With SATURATE=0, acc keeps the low ACC_W bits.
- A result is produced when the last beat reaches stage 2. `out_data`/`out_ovf` then hold stable until the result is transferred.
- FSM (packet control): IDLE (no packet open) → ACCUM on accepted non-last beat → IDLE on accepted last beat. LINEAR beats never leave IDLE.
- Reserved mode 3 behaves exactly as LINEAR.

## Timing
- Two-stage pipeline:
  - S1: registered operands, first/last, mode.
  - S2: accumulator plus output register.
- A beat accepted at edge k loads S1 at edge k and reaches `out_data` at edge k+1. `out_valid` is high from edge k+1 until the transfer edge.
- Pipeline advance enable is `!(out_valid && !out_ready)`, and `in_ready` equals this enable. Result transfer and new-beat acceptance in the same cycle are both allowed, giving full throughput of 1 beat/cycle in LINEAR.
- While stalled, S1 and acc hold. No beat is dropped or duplicated.
- Reset values: `in_ready`=1, `out_valid`=0, `out_data`=0, `out_ovf`=0, acc=0, FSM=IDLE, S1 valid=0.
- Reset asserted mid-packet discards the partial packet and any unaccepted result. After release, the first beat is treated as a packet start.

## Structure
- Package `mac_pkg` holds:
  - mode constants `MAC_DOT`/`MAC_HORNER`/`MAC_LINEAR`
  - FSM state encoding
  - the ACC_W ≥ 2*DATA_W+1 check
- One sub-module, `mac_sat_step`: combinational full-width multiply-add with overflow detect and SATURATE clamp, instantiated once in S2.

## Test plan
- DOT, (3,4),(5,6),(7,8,last) → one result 98, `out_ovf`=0, `out_valid` one edge after the last beat's accept edge.
- HORNER x=2, coefficients 1,0,3 (last on 3) → 7. A following DOT packet (2,2,last) → 4, proving the accumulator clears between packets.
- LINEAR a=b=c=255, 4 back-to-back beats with `out_ready`=1 → four results of 65280 on consecutive cycles, `in_ready` constantly 1.
- DOT, 17 beats of (255,255), SATURATE=1 → 0xFFFFF with `out_ovf`=1. With SATURATE=0 → 56849 with `out_ovf`=1. A 16-beat packet gives 1040400 with `out_ovf`=0.
- Backpressure: LINEAR stream with `out_ready` low for 5 cycles → `in_ready` drops within one cycle, `out_data` stable throughout, all results delivered in order with none lost.
- `reset_n` pulsed low after 2 beats of a DOT packet → outputs return to reset values. The next packet (1,1,last) yields 1.
